// File: rtl/decode_queue.sv
// RV32 decode stage: decodes fetched (pc, inst) pairs on enqueue and buffers the
// decoded bundles in a QDEPTH-entry FIFO in front of execute.
module decode_queue #(
    parameter int QDEPTH   = 2,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_pc,
    input  logic [31:0]               in_inst,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_pc,
    output logic [6:0]                out_opcode,
    output logic [4:0]                out_rd,
    output logic [4:0]                out_rs1,
    output logic [4:0]                out_rs2,
    output logic [2:0]                out_funct3,
    output logic [6:0]                out_funct7,
    output logic [4:0]                out_shamt,
    output logic [31:0]               out_imm,
    output logic                      out_PCSel,
    output logic                      out_RegWEn,
    output logic                      out_ASel,
    output logic                      out_BSel,
    output logic                      out_MemRW,
    output logic                      out_LoadUnsigned,
    output logic                      out_IsJALR,
    output logic                      out_IsBranch,
    output logic [2:0]                out_ImmSel,
    output logic [3:0]                out_ALUSel,
    output logic [1:0]                out_WBSel,
    output logic [1:0]                out_LoadSize,
    output logic [1:0]                out_StoreSize,
    output logic                      out_IsMul,
    output logic [2:0]                out_MulOp,
    output logic                      out_illegal,
    output logic [$clog2(QDEPTH):0]   count
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    localparam logic       PC_PLUS4 = 1'b0, PC_ALU = 1'b1;
    localparam logic       A_REG = 1'b0, A_PC = 1'b1;
    localparam logic       B_REG = 1'b0, B_IMM = 1'b1;
    localparam logic       MEM_READ = 1'b0, MEM_WRITE = 1'b1;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3,
                           IMM_J = 3'd4, IMM_SH = 3'd5;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_COPYB = 4'd10;
    localparam logic [1:0] WB_MEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2;
    localparam logic [1:0] LS_W = 2'd2;

    localparam logic [6:0] OP_R = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic        pc_sel;
        logic        reg_wen;
        logic        a_sel;
        logic        b_sel;
        logic        mem_rw;
        logic        load_unsigned;
        logic        is_jalr;
        logic        is_branch;
        logic [2:0]  imm_sel;
        logic [3:0]  alu_sel;
        logic [1:0]  wb_sel;
        logic [1:0]  load_size;
        logic [1:0]  store_size;
        logic        is_mul;
        logic [2:0]  mul_op;
        logic        illegal;
    } entry_t;

    function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    entry_t          dec;
    logic            legal;
    logic            use_imm;
    logic [2:0]      f3;
    logic [6:0]      f7;

    always_comb begin
        dec            = '0;
        f3             = in_inst[14:12];
        f7             = in_inst[31:25];
        dec.pc         = in_pc;
        dec.opcode     = in_inst[6:0];
        dec.rd         = in_inst[11:7];
        dec.rs1        = in_inst[19:15];
        dec.rs2        = in_inst[24:20];
        dec.funct3     = f3;
        dec.funct7     = f7;
        dec.shamt      = in_inst[24:20];
        dec.pc_sel     = PC_PLUS4;
        dec.a_sel      = A_REG;
        dec.b_sel      = B_REG;
        dec.mem_rw     = MEM_READ;
        dec.imm_sel    = IMM_I;
        dec.alu_sel    = ALU_ADD;
        dec.wb_sel     = WB_ALU;
        dec.load_size  = LS_W;
        dec.store_size = LS_W;
        legal          = 1'b1;
        use_imm        = 1'b1;
        case (in_inst[6:0])
            OP_R: begin
                use_imm     = 1'b0;
                dec.reg_wen = 1'b1;
                if (ENABLE_M && f7 == 7'b0000001) begin
                    dec.is_mul = 1'b1;
                    dec.mul_op = f3;
                end else if (f7 == 7'b0000000) begin
                    dec.alu_sel = alu_of_f3(f3);
                end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    dec.alu_sel = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_IMM: begin
                dec.reg_wen = 1'b1;
                dec.b_sel   = B_IMM;
                if (f3 == 3'b001) begin
                    dec.imm_sel = IMM_SH;
                    dec.alu_sel = ALU_SLL;
                    legal       = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    dec.imm_sel = IMM_SH;
                    dec.alu_sel = f7[5] ? ALU_SRA : ALU_SRL;
                    legal       = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                end else begin
                    dec.alu_sel = alu_of_f3(f3);
                end
            end
            OP_LOAD: begin
                dec.reg_wen       = 1'b1;
                dec.b_sel         = B_IMM;
                dec.wb_sel        = WB_MEM;
                dec.load_size     = f3[1:0];
                dec.load_unsigned = f3[2];
                legal             = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
            end
            OP_STORE: begin
                dec.b_sel      = B_IMM;
                dec.mem_rw     = MEM_WRITE;
                dec.imm_sel    = IMM_S;
                dec.store_size = f3[1:0];
                legal          = (f3 <= 3'b010);
            end
            OP_BRANCH: begin
                // Branch target is pc+imm through the ALU; the bcu decides taken.
                dec.a_sel     = A_PC;
                dec.b_sel     = B_IMM;
                dec.imm_sel   = IMM_B;
                dec.is_branch = 1'b1;
            end
            OP_JAL: begin
                dec.reg_wen = 1'b1;
                dec.pc_sel  = PC_ALU;
                dec.a_sel   = A_PC;
                dec.b_sel   = B_IMM;
                dec.imm_sel = IMM_J;
                dec.wb_sel  = WB_PC4;
            end
            OP_JALR: begin
                dec.reg_wen = 1'b1;
                dec.pc_sel  = PC_ALU;
                dec.b_sel   = B_IMM;
                dec.is_jalr = 1'b1;
                dec.wb_sel  = WB_PC4;
            end
            OP_LUI: begin
                dec.reg_wen = 1'b1;
                dec.b_sel   = B_IMM;
                dec.imm_sel = IMM_U;
                dec.alu_sel = ALU_COPYB;
            end
            OP_AUIPC: begin
                dec.reg_wen = 1'b1;
                dec.a_sel   = A_PC;
                dec.b_sel   = B_IMM;
                dec.imm_sel = IMM_U;
            end
            default: legal = 1'b0;
        endcase

        if (use_imm) begin
            case (dec.imm_sel)
                IMM_S:   dec.imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                IMM_B:   dec.imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                    in_inst[30:25], in_inst[11:8], 1'b0};
                IMM_U:   dec.imm = {in_inst[31:12], 12'b0};
                IMM_J:   dec.imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                    in_inst[20], in_inst[30:21], 1'b0};
                IMM_SH:  dec.imm = {27'b0, in_inst[24:20]};
                default: dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
            endcase
        end

        // Illegal encodings keep their raw fields but carry an inert control bundle.
        if (!legal) begin
            dec.pc_sel        = PC_PLUS4;
            dec.reg_wen       = 1'b0;
            dec.a_sel         = A_REG;
            dec.b_sel         = B_REG;
            dec.mem_rw        = MEM_READ;
            dec.load_unsigned = 1'b0;
            dec.is_jalr       = 1'b0;
            dec.is_branch     = 1'b0;
            dec.imm_sel       = IMM_I;
            dec.alu_sel       = ALU_ADD;
            dec.wb_sel        = WB_ALU;
            dec.load_size     = LS_W;
            dec.store_size    = LS_W;
            dec.is_mul        = 1'b0;
            dec.mul_op        = 3'b0;
            dec.imm           = '0;
            dec.illegal       = 1'b1;
        end
        if (dec.rd == 5'd0) dec.reg_wen = 1'b0;
    end

    entry_t          mem_q [QDEPTH];
    entry_t          mem_d [QDEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < QDEPTH; k++) mem_q[k] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    entry_t head;
    assign head             = mem_q[rd_ptr_q];
    assign count            = count_q;
    assign out_pc           = head.pc;
    assign out_opcode       = head.opcode;
    assign out_rd           = head.rd;
    assign out_rs1          = head.rs1;
    assign out_rs2          = head.rs2;
    assign out_funct3       = head.funct3;
    assign out_funct7       = head.funct7;
    assign out_shamt        = head.shamt;
    assign out_imm          = head.imm;
    assign out_PCSel        = head.pc_sel;
    assign out_RegWEn       = head.reg_wen;
    assign out_ASel         = head.a_sel;
    assign out_BSel         = head.b_sel;
    assign out_MemRW        = head.mem_rw;
    assign out_LoadUnsigned = head.load_unsigned;
    assign out_IsJALR       = head.is_jalr;
    assign out_IsBranch     = head.is_branch;
    assign out_ImmSel       = head.imm_sel;
    assign out_ALUSel       = head.alu_sel;
    assign out_WBSel        = head.wb_sel;
    assign out_LoadSize     = head.load_size;
    assign out_StoreSize    = head.store_size;
    assign out_IsMul        = head.is_mul;
    assign out_MulOp        = head.mul_op;
    assign out_illegal      = head.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (ENABLE_M=1 at index 1, ENABLE_M=0 at index 0)
// share stimulus and are compared against a queue + decode reference model.
module tb_decode_queue;
    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_inst;

    logic        o_in_ready[2], o_valid[2];
    logic [31:0] o_pc[2], o_imm[2];
    logic [6:0]  o_opcode[2], o_funct7[2];
    logic [4:0]  o_rd[2], o_rs1[2], o_rs2[2], o_shamt[2];
    logic [2:0]  o_funct3[2], o_ImmSel[2], o_MulOp[2];
    logic        o_PCSel[2], o_RegWEn[2], o_ASel[2], o_BSel[2], o_MemRW[2];
    logic        o_LoadUnsigned[2], o_IsJALR[2], o_IsBranch[2], o_IsMul[2], o_illegal[2];
    logic [3:0]  o_ALUSel[2];
    logic [1:0]  o_WBSel[2], o_LoadSize[2], o_StoreSize[2], o_count[2];
    logic [126:0] obs[2];

    int checks = 0;
    int errors = 0;
    logic [31:0] pcq[$];
    logic [31:0] iq[$];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_queue #(.QDEPTH(2), .ENABLE_M(g == 1)) dut (
            .clock(clock), .reset(reset), .flush(flush),
            .in_valid(in_valid), .in_ready(o_in_ready[g]), .in_pc(in_pc), .in_inst(in_inst),
            .out_valid(o_valid[g]), .out_ready(out_ready), .out_pc(o_pc[g]),
            .out_opcode(o_opcode[g]), .out_rd(o_rd[g]), .out_rs1(o_rs1[g]), .out_rs2(o_rs2[g]),
            .out_funct3(o_funct3[g]), .out_funct7(o_funct7[g]), .out_shamt(o_shamt[g]),
            .out_imm(o_imm[g]), .out_PCSel(o_PCSel[g]), .out_RegWEn(o_RegWEn[g]),
            .out_ASel(o_ASel[g]), .out_BSel(o_BSel[g]), .out_MemRW(o_MemRW[g]),
            .out_LoadUnsigned(o_LoadUnsigned[g]), .out_IsJALR(o_IsJALR[g]),
            .out_IsBranch(o_IsBranch[g]), .out_ImmSel(o_ImmSel[g]), .out_ALUSel(o_ALUSel[g]),
            .out_WBSel(o_WBSel[g]), .out_LoadSize(o_LoadSize[g]), .out_StoreSize(o_StoreSize[g]),
            .out_IsMul(o_IsMul[g]), .out_MulOp(o_MulOp[g]), .out_illegal(o_illegal[g]),
            .count(o_count[g])
        );
        assign obs[g] = {o_pc[g], o_opcode[g], o_rd[g], o_rs1[g], o_rs2[g], o_funct3[g],
                         o_funct7[g], o_shamt[g], o_imm[g], o_PCSel[g], o_RegWEn[g], o_ASel[g],
                         o_BSel[g], o_MemRW[g], o_LoadUnsigned[g], o_IsJALR[g], o_IsBranch[g],
                         o_ImmSel[g], o_ALUSel[g], o_WBSel[g], o_LoadSize[g], o_StoreSize[g],
                         o_IsMul[g], o_MulOp[g], o_illegal[g]};
    end

    // ALU codes: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 COPYB10
    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        logic [3:0] tab [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        return tab[f3];
    endfunction

    // Reference decode: result laid out in the same order as obs[].
    function automatic logic [126:0] model(input logic [31:0] pc, input logic [31:0] i,
                                           input bit en_m);
        logic [6:0] opc, f7;
        logic [2:0] f3, immsel, mop;
        logic pcsel, regwen, asel, bsel, memrw, lu, jalr, br, mul, ill;
        logic [3:0] alu;
        logic [1:0] wb, ls, ss;
        logic [31:0] imm, ii;
        opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        {pcsel, regwen, asel, bsel, memrw, lu, jalr, br, mul, ill} = '0;
        immsel = 0; mop = 0; alu = 0; wb = 1; ls = 2; ss = 2; imm = 0;
        ii = 32'($signed(i) >>> 20);
        case (opc)
            7'h33: begin
                regwen = 1;
                if (f7 == 0) alu = f3_alu(f3);
                else if (f7 == 7'h20 && f3 == 0) alu = 1;
                else if (f7 == 7'h20 && f3 == 5) alu = 7;
                else if (en_m && f7 == 1) begin mul = 1; mop = f3; end
                else ill = 1;
            end
            7'h13: begin
                regwen = 1; bsel = 1;
                if (f3 == 1 || f3 == 5) begin
                    immsel = 5; imm = {27'b0, i[24:20]};
                    alu = (f3 == 1) ? 4'd2 : ((f7 == 7'h20) ? 4'd7 : 4'd6);
                    ill = !(f7 == 0 || (f3 == 5 && f7 == 7'h20));
                end else begin
                    imm = ii; alu = f3_alu(f3);
                end
            end
            7'h03: begin
                regwen = 1; bsel = 1; wb = 0; imm = ii; ls = f3[1:0]; lu = f3[2];
                ill = (f3 == 3 || f3 >= 6);
            end
            7'h23: begin
                bsel = 1; memrw = 1; immsel = 1; ss = f3[1:0]; ill = (f3 > 2);
                imm = (ii & ~32'h1F) | {27'b0, i[11:7]};
            end
            7'h63: begin
                asel = 1; bsel = 1; br = 1; immsel = 2;
                imm = (i[31] ? 32'hFFFFF000 : 32'h0) | {20'b0, i[7], i[30:25], i[11:8], 1'b0};
            end
            7'h6F: begin
                pcsel = 1; asel = 1; bsel = 1; immsel = 4; wb = 2; regwen = 1;
                imm = (i[31] ? 32'hFFF00000 : 32'h0) | {12'b0, i[19:12], i[20], i[30:21], 1'b0};
            end
            7'h67: begin pcsel = 1; bsel = 1; jalr = 1; wb = 2; regwen = 1; imm = ii; end
            7'h37: begin bsel = 1; immsel = 3; alu = 10; regwen = 1; imm = i & 32'hFFFFF000; end
            7'h17: begin asel = 1; bsel = 1; immsel = 3; regwen = 1; imm = i & 32'hFFFFF000; end
            default: ill = 1;
        endcase
        if (ill) begin
            {pcsel, regwen, asel, bsel, memrw, lu, jalr, br, mul} = '0;
            immsel = 0; mop = 0; alu = 0; wb = 1; ls = 2; ss = 2; imm = 0;
        end
        if (i[11:7] == 0) regwen = 0;
        return {pc, opc, i[11:7], i[19:15], i[24:20], f3, f7, i[24:20], imm, pcsel, regwen,
                asel, bsel, memrw, lu, jalr, br, immsel, alu, wb, ls, ss, mul, mop, ill};
    endfunction

    task automatic chk(input string tag, input logic [126:0] o, input logic [126:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic check_all();
        int n;
        n = iq.size();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("count[%0d]", g), 127'(o_count[g]), 127'(n));
            chk($sformatf("in_ready[%0d]", g), 127'(o_in_ready[g]), 127'(n < 2));
            chk($sformatf("out_valid[%0d]", g), 127'(o_valid[g]), 127'(n != 0));
            if (n != 0) chk($sformatf("head[%0d]", g), obs[g], model(pcq[0], iq[0], g == 1));
        end
    endtask

    // One clock: model the handshake from current inputs, then compare #1 after the edge.
    task automatic tick();
        bit push, pop;
        push = in_valid && (iq.size() < 2) && !flush;
        pop  = (iq.size() != 0) && out_ready && !flush;
        @(posedge clock);
        #1;
        if (flush) begin
            pcq.delete(); iq.delete();
        end else begin
            if (pop) begin void'(pcq.pop_front()); void'(iq.pop_front()); end
            if (push) begin pcq.push_back(in_pc); iq.push_back(in_inst); end
        end
        check_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy);
        in_valid = v; in_pc = pc; in_inst = inst; out_ready = rdy;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) w[6:0] = ops[k];
        if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
            w[31:25] = f7s[$urandom_range(0, 3)];
        return w;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #12;
        for (int g = 0; g < 2; g++) chk($sformatf("reset_bundle[%0d]", g), obs[g], '0);
        check_all();
        reset = 1'b0;

        // addi x1,x0,5 at pc 0x100, consumed the cycle after it appears
        drive(1'b1, 32'h100, 32'h00500093, 1'b1);
        tick();
        chk("addi_rd", 127'(o_rd[1]), 127'(1));
        chk("addi_imm", 127'(o_imm[1]), 127'(5));
        chk("addi_regwen_bsel_alu", {o_RegWEn[1], o_BSel[1], o_ALUSel[1]}, {1'b1, 1'b1, 4'd0});
        chk("addi_pc", 127'(o_pc[1]), 127'(32'h100));
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("addi_drained", 127'(o_valid[1]), 127'(0));

        // backpressure: third push held off until the queue drains
        drive(1'b1, 32'h200, 32'h00108113, 1'b0); tick();
        drive(1'b1, 32'h204, 32'h40208233, 1'b0); tick();
        chk("bp_full_ready", 127'(o_in_ready[1]), 127'(0));
        drive(1'b1, 32'h208, 32'h00f00293, 1'b0); tick();
        chk("bp_third_blocked", 127'(o_count[1]), 127'(2));
        chk("bp_head_still_first", 127'(o_pc[1]), 127'(32'h200));
        out_ready = 1'b1; tick();
        chk("bp_no_passthru", 127'(o_count[1]), 127'(1));
        tick();
        chk("bp_third_in", 127'(o_pc[1]), 127'(32'h208));
        drive(1'b0, 32'h0, 32'h0, 1'b1); tick();

        // beq x0,x0,-4 then addi x0,x0,0
        drive(1'b1, 32'h300, 32'hFE000EE3, 1'b0); tick();
        chk("beq_imm", 127'(o_imm[1]), 127'(32'hFFFFFFFC));
        chk("beq_ctrl", {o_IsBranch[1], o_ASel[1], o_RegWEn[1]}, {1'b1, 1'b1, 1'b0});
        out_ready = 1'b1; in_inst = 32'h00000013; in_pc = 32'h304; tick();
        chk("nop_ctrl", {o_RegWEn[1], o_illegal[1]}, {1'b0, 1'b0});

        // mul x3,x1,x2 on both instances, then an unknown opcode
        in_inst = 32'h022081B3; in_pc = 32'h400; tick();
        chk("mul_m1", {o_IsMul[1], o_MulOp[1], o_RegWEn[1], o_illegal[1]},
            {1'b1, 3'd0, 1'b1, 1'b0});
        chk("mul_m0", {o_illegal[0], o_RegWEn[0], o_IsMul[0]}, {1'b1, 1'b0, 1'b0});
        in_inst = 32'h1234517F; in_pc = 32'h404; tick();
        chk("op7f_illegal", {o_illegal[1], o_illegal[0], o_imm[1]}, {1'b1, 1'b1, 32'h0});

        // flush at full occupancy beats a concurrent push
        drive(1'b1, 32'h500, 32'h00100093, 1'b0); tick(); tick();
        flush = 1'b1; in_pc = 32'h508; tick();
        chk("flush_empty", {o_count[1], o_valid[1], o_in_ready[1]}, {2'd0, 1'b0, 1'b1});
        flush = 1'b0; in_valid = 1'b0; tick();
        chk("flush_dropped", 127'(o_valid[1]), 127'(0));

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom, rand_inst(), $urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush = 1'b0;

        // async reset mid-cycle with one entry held
        drive(1'b0, 32'h0, 32'h0, 1'b1); tick(); tick();
        drive(1'b1, 32'h600, 32'h00A00513, 1'b0); tick();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        pcq.delete(); iq.delete();
        chk("async_rst_state", {o_count[1], o_valid[1], o_in_ready[1]}, {2'd0, 1'b0, 1'b1});
        chk("async_rst_bundle", obs[1], '0);
        #1 reset = 1'b0;
        drive(1'b1, 32'h700, 32'h00C00593, 1'b1); tick();
        chk("post_rst_push_pc", 127'(o_pc[1]), 127'(32'h700));
        in_valid = 1'b0; tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
# decode_queue

Registered, parametrised decode stage for the RV32 core. It accepts fetched (pc, inst) pairs over a valid/ready handshake and decodes each one into fields, immediate and control bundle at enqueue. Decoded entries are held in a QDEPTH-entry FIFO and presented to execute over a second valid/ready handshake. Beyond the base decoder it adds optional M-extension decode, illegal-instruction flagging, x0 write suppression, flush, and backpressure, decoupling fetch from execute.

## Interface
- QDEPTH, 2, FIFO entries; power of two, ≥2
- ENABLE_M, 0, 1 = decode RV32M (funct7=0000001 under opcode 0110011); 0 = flag those encodings illegal
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous; empties FIFO
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  = (count < QDEPTH)
- in_pc  in  32  instruction address
- in_inst  in  32  instruction word
- out_valid  out  1  = (count != 0)
- out_ready  in  1  execute consumes head
- out_pc  out  32  head pc
- out_opcode / out_rd / out_rs1 / out_rs2 / out_funct3 / out_funct7 / out_shamt  out  7/5/5/5/3/7/5  raw fields of head
- out_imm  out  32  sign-extended/padded immediate
- out_PCSel, out_RegWEn, out_ASel, out_BSel, out_MemRW, out_LoadUnsigned, out_IsJALR, out_IsBranch  out  1 each  control; encodings from control_defs.vh
- out_ImmSel  out  3;  out_ALUSel  out  4;  out_WBSel, out_LoadSize, out_StoreSize  out  2 each
- out_IsMul  out  1  head is an M-extension op
- out_MulOp  out  3  funct3 of the M op (MUL=0 … REMU=7); 0 when IsMul=0
- out_illegal  out  1  head encoding unsupported
- count  out  $clog2(QDEPTH)+1  occupancy

## Operation
- Decode is combinational on in_inst, with results written into FIFO entry [wr_ptr] on push. Fields and immediates: I = {{20{i[31]}},i[31:20]}; shifts-immediate = {27'b0,shamt}; S = {{20{i[31]}},i[31:25],i[11:7]}; B = {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],0}; U = {i[31:12],12'b0}; J = {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],0}.
- Control per opcode: R, I-arith, load, store, branch, JAL, JALR, LUI, AUIPC; defaults PC_PLUS4, ALU_ADD, A_REG, B_REG, MEM_READ, WB_ALU, LS_W.
- Branch: ASel=A_PC, BSel=B_IMM, PCSel=PC_PLUS4; the bcu resolves.
- Illegal = 1 in these cases:
  - unknown opcode;
  - R-type funct7 not 0000000, or 0100000 with funct3 ∉ {000,101}, unless ENABLE_M && funct7=0000001;
  - shift-immediate funct7 ∉ {0000000, 0100000 for 101};
  - load funct3 ∈ {011,110,111};
  - store funct3 > 010.
- Illegal entries carry RegWEn=0, MemRW=MEM_READ, IsJALR=0, IsBranch=0, IsMul=0, imm=0.
- M op: RegWEn=1, IsMul=1, MulOp=funct3, ALUSel=ALU_ADD (don't care).
- x0 suppression: RegWEn forced 0 whenever rd=0.
- FIFO actions:
  - push = in_valid && in_ready;
  - pop = out_valid && out_ready;
  - pointers wrap modulo QDEPTH;
  - count += push − pop.
- Simultaneous push+pop: allowed when 0<count<QDEPTH; count unchanged. At count=QDEPTH, in_ready=0, so there is no push even if pop occurs that cycle (no pass-through).
- flush has priority over push and pop in the same cycle: pointers→0, count→0, and the incoming instruction is dropped.

## Timing
- Reset (async assert, any cycle including mid-transfer) forces:
  - count=0, pointers=0, out_valid=0, in_ready=1;
  - all stored entries=0, so all out_* read 0, including out_illegal.
- Latency: push at edge N → out_valid=1 with decoded head from edge N (readable in cycle N+1). No same-cycle combinational path from in_* to out_*.
- out_* are driven from the storage of entry [rd_ptr] and are stable while out_valid && !out_ready.
- in_ready depends only on count, not on out_ready.
- Throughput is 1 instruction/cycle while count < QDEPTH.
- After flush at edge N: out_valid=0 and in_ready=1 in cycle N+1.

## Test plan
- Reset, then push addi x1,x0,5 (0x00500093, pc 0x100), out_ready=1 → next cycle: out_valid=1, rd=1, imm=5, RegWEn=1, BSel=B_IMM, ALUSel=ALU_ADD, out_pc=0x100; then out_valid=0.
- QDEPTH=2, out_ready=0, push 3 consecutive instructions → in_ready=0 after 2 pushes, count=2, third not accepted. Raise out_ready → entries drain in order, third accepted once count<2.
- beq x0,x0,-4 (0xFE000EE3) → imm=0xFFFFFFFC, IsBranch=1, ASel=A_PC, RegWEn=0. addi x0,x0,0 (0x00000013) → RegWEn=0, illegal=0.
- mul x3,x1,x2 (0x022081B3): ENABLE_M=1 → IsMul=1, MulOp=0, RegWEn=1, illegal=0. ENABLE_M=0 → illegal=1, RegWEn=0. Opcode 0x7F → illegal=1.
- count=2 with flush asserted together with in_valid=1 → next cycle count=0, out_valid=0, pushed instruction absent.
- Assert reset asynchronously mid-cycle with count=1 → count=0 and out_valid=0 immediately, before the next edge. Subsequent push works from pointer 0.
